// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: architectural width, PC reset vector, and
// instruction size in bytes.
package cpu_pkg;
  localparam int          XLEN            = 32;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam int          INSTR_BYTES     = 4;
endpackage

// File: rtl/pc_incr.sv
// Constant-increment adder that produces the sequential next address.
// The sum wraps modulo 2^WIDTH.
module pc_incr #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_sum
);
  assign o_sum = i_a + WIDTH'(INC);
endmodule

// File: rtl/pc.sv
// Program counter: a register loaded with IN on every edge (reset has priority),
// plus a PC+4 output and a word-misalignment flag.
module pc
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_PLUS4,
  output logic             MISALIGNED
);
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_plus4;

  // No enable and no alignment masking: every bit of IN, including [1:0], is stored.
  always_ff @(posedge CLK) begin
    if (RST) r_pc <= RESET_VECTOR;
    else     r_pc <= IN;
  end

  pc_incr #(.WIDTH(WIDTH), .INC(INSTR_BYTES)) u_incr (
    .i_a  (r_pc),
    .o_sum(w_plus4)
  );

  assign OUT        = r_pc;
  assign OUT_PLUS4  = w_plus4;
  assign MISALIGNED = |r_pc[1:0];
endmodule

// File: tb/tb_pc.sv
// Testbench for pc. It runs a directed sequence and then random RST/IN traffic.
// Both a default-vector instance and a non-default-vector instance are checked
// against an arithmetic reference model.
module tb_pc;
  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'h0040_0000;

  logic        CLK, RST;
  logic [31:0] IN;
  logic [31:0] out0, p40, out1, p41;
  logic        mis0, mis1;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc0, m_pc1;
  bit          m_valid = 0;

  pc u_dut0 (
    .CLK(CLK), .RST(RST), .IN(IN),
    .OUT(out0), .OUT_PLUS4(p40), .MISALIGNED(mis0)
  );

  pc #(.RESET_VECTOR(RV1)) u_dut1 (
    .CLK(CLK), .RST(RST), .IN(IN),
    .OUT(out1), .OUT_PLUS4(p41), .MISALIGNED(mis1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Compare both instances against the model. The expected values come from
  // the model PC with plain arithmetic.
  task automatic chk_all(input string tag);
    chk({tag, "/out0"}, out0, m_pc0);
    chk({tag, "/p40"},  p40,  m_pc0 + 32'd4);
    chk({tag, "/mis0"}, {31'd0, mis0}, {31'd0, (m_pc0 % 4) != 0});
    chk({tag, "/out1"}, out1, m_pc1);
    chk({tag, "/p41"},  p41,  m_pc1 + 32'd4);
    chk({tag, "/mis1"}, {31'd0, mis1}, {31'd0, (m_pc1 % 4) != 0});
  endtask

  // Drive inputs on the falling edge. Before the rising edge, confirm the
  // outputs have not yet changed. Then apply the model rule and check #1 after
  // the rising edge.
  task automatic step(input logic rst, input logic [31:0] din, input string tag);
    @(negedge CLK);
    RST = rst;
    IN  = din;
    #1;
    if (m_valid) begin
      chk({tag, "/early0"}, out0, m_pc0);
      chk({tag, "/early1"}, out1, m_pc1);
    end
    @(posedge CLK);
    m_pc0   = rst ? RV0 : din;
    m_pc1   = rst ? RV1 : din;
    m_valid = 1;
    #1;
    chk_all(tag);
  endtask

  initial begin
    RST = 1'b0;
    IN  = 32'h0;

    step(1'b1, 32'hDEAD_BEEF, "reset");
    chk("reset_out0_const", out0, 32'h0000_0000);
    chk("reset_p41_const",  p41,  32'h0040_0004);

    step(1'b0, 32'h0000_0000, "ld0");
    step(1'b0, 32'h0000_0001, "ld1");
    chk("mis_at_1", {31'd0, mis0}, 32'd1);
    chk("p4_at_1",  p40, 32'd5);
    step(1'b0, 32'h1234_5678, "ld12345678");
    chk("p4_at_12345678", p40, 32'h1234_567C);
    step(1'b0, 32'hABCD_EF01, "ldABCDEF01");
    chk("mis_at_ABCDEF01", {31'd0, mis0}, 32'd1);
    step(1'b0, 32'hFFFF_FFFF, "ldFFFFFFFF");
    chk("wrap_ffffffff", p40, 32'h0000_0003);
    step(1'b0, 32'h0000_0000, "ld0b");
    step(1'b0, 32'hFFFF_FFFC, "ldFFFFFFFC");
    chk("wrap_fffffffc", p40, 32'h0000_0000);

    step(1'b1, 32'h0000_0040, "rst_prio");
    chk("rst_prio_out0", out0, 32'h0000_0000);
    step(1'b0, 32'h0000_0040, "rst_release");
    chk("rst_release_out0", out0, 32'h0000_0040);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic        r;
      logic [31:0] d;
      r = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: d = $urandom;
      endcase
      step(r, d, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc.md
# pc

Program counter register for the single-cycle CPU datapath. Holds the address of the current instruction and updates to the next-PC value on every rising clock edge. Sits between the next-PC mux (adder / branch / jump select) and the instruction-memory address port. Also provides the sequential next address (PC+4) and a word-misalignment flag for downstream logic.

## Interface

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into the PC on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous and active-high; loads RESET_VECTOR.
- IN  input  WIDTH  next-PC value to load.
- OUT  output  WIDTH  current PC, registered.
- OUT_PLUS4  output  WIDTH  OUT + 4, combinational from OUT, wraps modulo 2^WIDTH.
- MISALIGNED  output  1  high when OUT[1:0] != 2'b00, combinational from OUT.

One clock (CLK). Reset is synchronous and active-high (RST).

## Operation

- On each rising CLK edge:
  - If RST = 1: OUT <= RESET_VECTOR.
  - Otherwise: OUT <= IN, unconditionally. No enable and no stall input.
- RST has priority over IN whenever both are active on the same edge.
- No filtering or alignment of IN. The register stores all WIDTH bits as given, including bits [1:0].
- MISALIGNED only reports misalignment. It does not alter the stored value.
- OUT_PLUS4 = OUT + 4, truncated to WIDTH bits:
  - OUT = 32'hFFFF_FFFC gives 32'h0000_0000.
  - OUT = 32'hFFFF_FFFF gives 32'h0000_0003.
- Reset values: OUT = RESET_VECTOR, OUT_PLUS4 = RESET_VECTOR + 4, MISALIGNED = (RESET_VECTOR[1:0] != 0).
- With the default vector these are 0, 4 and 0.
- Before the first reset or load edge, OUT is unknown (X in simulation). Benches must reset first or drive a defined IN before checking.

## Timing

- Latency: IN is sampled on a rising edge and appears on OUT immediately after that edge (1-cycle register).
- OUT_PLUS4 and MISALIGNED follow OUT combinationally in the same cycle.
- IN must be stable across the setup/hold window of the rising edge. Changes between edges, for example on the falling edge, have no effect until the next rising edge.
- Asserting RST for a single edge is sufficient.
- Deasserting RST: the first edge with RST = 0 loads IN.
- Asserting RST mid-stream discards the pending IN on that edge.
- Glitches on RST between edges have no effect, since reset is synchronous.

## Structure

- Shared package cpu_pkg:
  - XLEN = 32.
  - PC_RESET_VECTOR = 32'h0000_0000.
  - INSTR_BYTES = 4 (increment constant).
- PC uses these as its parameter defaults.
- One natural sub-module: pc_incr, a parameterized WIDTH-bit constant adder producing OUT_PLUS4. The register and misalignment check stay in PC.

## Test plan

- Reset: RST = 1 for one edge with IN = 32'hDEAD_BEEF.
  - Required: OUT = 0, OUT_PLUS4 = 4, MISALIGNED = 0.
- Load sequence (clock period 10 ns), with IN changed on falling edges to 0, 1, 32'h1234_5678, 32'hABCD_EF01, 32'hFFFF_FFFF, 0:
  - Required: OUT equals each value after the following rising edge, one cycle late, never earlier.
- Misalignment:
  - OUT = 1: MISALIGNED = 1, OUT_PLUS4 = 5.
  - OUT = 32'h1234_5678: MISALIGNED = 0, OUT_PLUS4 = 32'h1234_567C.
  - OUT = 32'hABCD_EF01: MISALIGNED = 1.
- Wrap-around:
  - OUT = 32'hFFFF_FFFC: OUT_PLUS4 = 0.
  - OUT = 32'hFFFF_FFFF: OUT_PLUS4 = 3, MISALIGNED = 1.
- Reset priority: RST = 1 and IN = 32'h0000_0040 on the same edge.
  - Required: OUT = RESET_VECTOR.
  - On the next edge with RST = 0, OUT = 32'h0000_0040.
- Non-default RESET_VECTOR = 32'h0040_0000: reset edge.
  - Required: OUT = 32'h0040_0000, OUT_PLUS4 = 32'h0040_0004.
